integrate_dump: RTL and testbench

//  Stream consumer for the widened sum produced by the adder stage.
//  - Accepts DATA_W+1-bit signed samples over valid/ready and sums N consecutive

---
 rtl/dsp_stream_pkg.sv | 11 +
 rtl/integrate_dump.sv | 100 ++++++++++
 tb/tb_integrate_dump.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dsp_stream_pkg.sv
// Shared types and helpers for the sample-stream datapath blocks.
package dsp_stream_pkg;

  typedef enum logic {ST_ACCUM, ST_DUMP} idump_state_t;

  // $clog2 that never returns zero, so a counter always has at least one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/integrate_dump.sv
// Integrate-and-dump: sums N accepted signed samples and hands one full-precision
// result per window downstream over valid/ready.
module integrate_dump
  import dsp_stream_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int N      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_valid,
  input  logic [DATA_W:0]                  i_data,
  output logic                             o_ready,
  input  logic                             i_ready,
  output logic [DATA_W+$clog2(N):0]        o_sum,
  output logic                             o_valid
);

  localparam int IN_W  = DATA_W + 1;
  localparam int OUT_W = IN_W + $clog2(N);
  localparam int CNT_W = clog2_min1(N);

  idump_state_t             state_q, state_d;
  logic signed [OUT_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     valid_q, valid_d;

  logic signed [OUT_W-1:0]  sample_ext;
  logic                     acc_en;
  logic                     last_sample;

  assign sample_ext  = OUT_W'($signed(i_data));
  assign o_ready     = (state_q == ST_ACCUM) || i_ready;
  assign acc_en      = i_valid && o_ready;
  assign last_sample = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      ST_ACCUM: begin
        if (acc_en) begin
          if (last_sample) begin
            sum_d   = acc_q + sample_ext;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_DUMP;
          end else begin
            acc_d = acc_q + sample_ext;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DUMP: begin
        if (i_ready) begin
          if (i_valid) begin
            // Result leaves and the next window's first sample arrives together.
            if (N == 1) begin
              sum_d = sample_ext;
            end else begin
              valid_d = 1'b0;
              acc_d   = sample_ext;
              cnt_d   = CNT_W'(1);
              state_d = ST_ACCUM;
            end
          end else begin
            valid_d = 1'b0;
            state_d = ST_ACCUM;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign o_sum   = sum_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_integrate_dump.sv
// Bench for integrate_dump: three instances (N=4, N=8, N=1) checked every cycle
// against a window-queue model, plus directed scenarios with fixed expected sums.
module tb_integrate_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        vld [3];
  logic        rdy [3];
  logic        orp [3];
  logic        ov  [3];
  logic [24:0] dat [3];
  logic [26:0] sum0;
  logic [27:0] sum1;
  logic [24:0] sum2;

  always #5 clk = ~clk;

  integrate_dump #(.DATA_W(24), .N(4)) u_n4 (
    .clk(clk), .reset(reset), .i_valid(vld[0]), .i_data(dat[0]), .o_ready(orp[0]),
    .i_ready(rdy[0]), .o_sum(sum0), .o_valid(ov[0]));
  integrate_dump #(.DATA_W(24), .N(8)) u_n8 (
    .clk(clk), .reset(reset), .i_valid(vld[1]), .i_data(dat[1]), .o_ready(orp[1]),
    .i_ready(rdy[1]), .o_sum(sum1), .o_valid(ov[1]));
  integrate_dump #(.DATA_W(24), .N(1)) u_n1 (
    .clk(clk), .reset(reset), .i_valid(vld[2]), .i_data(dat[2]), .o_ready(orp[2]),
    .i_ready(rdy[2]), .o_sum(sum2), .o_valid(ov[2]));

  int     tests = 0;
  int     fails = 0;
  int     nwin [3] = '{4, 8, 1};
  bit     m_pend [3];
  longint m_sum  [3];
  longint win [3][$];

  function automatic longint get_sum(input int j);
    case (j)
      0:       return longint'($signed(sum0));
      1:       return longint'($signed(sum1));
      default: return longint'($signed(sum2));
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_pend[j] = 1'b0;
      m_sum[j]  = 0;
      win[j].delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("%s_valid%0d", tag, j), longint'(ov[j]), longint'(m_pend[j]));
      chk($sformatf("%s_sum%0d", tag, j), get_sum(j), m_sum[j]);
    end
  endtask

  // One clock with DUT k driven; other instances idle with ready high.
  task automatic cyc(input int k, input bit v, input longint d, input bit r);
    bit acc [3];
    longint total;
    for (int j = 0; j < 3; j++) begin
      vld[j] = 1'b0;
      rdy[j] = 1'b1;
    end
    vld[k] = v;
    dat[k] = d[24:0];
    rdy[k] = r;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("ready%0d", j), longint'(orp[j]), longint'(!m_pend[j] || rdy[j]));
      acc[j] = vld[j] && (!m_pend[j] || rdy[j]);
    end
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      if (m_pend[j] && rdy[j]) m_pend[j] = 1'b0;
      if (acc[j]) begin
        win[j].push_back(longint'($signed(dat[j])));
        if (win[j].size() == nwin[j]) begin
          total = 0;
          foreach (win[j][i]) total += win[j][i];
          m_sum[j]  = total;
          m_pend[j] = 1'b1;
          win[j].delete();
        end
      end
    end
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic do_reset(input int k, input bit v, input longint d);
    reset  = 1'b1;
    vld[k] = v;
    dat[k] = d[24:0];
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outputs("rst");
    reset = 1'b0;
  endtask

  int     t4_exp [3] = '{10, 26, 42};
  int     t5_dat [3] = '{5, -3, 7};
  longint hold_sum;
  logic [24:0] rd;

  initial begin
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      vld[j] = 1'b0;
      rdy[j] = 1'b1;
      dat[j] = '0;
    end
    model_reset();
    @(negedge clk);
    do_reset(0, 1'b0, 0);
    for (int j = 0; j < 3; j++) chk($sformatf("rst_ready%0d", j), longint'(orp[j]), 1);
    chk("rst_sum_n8", get_sum(1), 0);

    // Window of 1..4 with downstream always ready.
    cyc(0, 1, 1, 1); cyc(0, 1, 2, 1); cyc(0, 1, 3, 1);
    cyc(0, 1, 4, 1);
    chk("t1_valid", longint'(ov[0]), 1);
    chk("t1_sum", get_sum(0), 10);
    cyc(0, 0, 0, 1);
    chk("t1_drop", longint'(ov[0]), 0);

    // Full-scale negative and near full-scale positive windows, N=8.
    for (int i = 0; i < 8; i++) cyc(1, 1, -16777216, 1);
    chk("t2_neg", get_sum(1), -134217728);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 16777214, 1);
    chk("t2_pos", get_sum(1), 134217712);
    cyc(1, 0, 0, 1);

    // Backpressure at the dump: stalled samples must not be counted.
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    cyc(0, 1, 2, 0);
    hold_sum = get_sum(0);
    chk("t3_dump", hold_sum, 5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 100, 0);
      chk("t3_stall_ready", longint'(orp[0]), 0);
      chk("t3_hold_sum", get_sum(0), 5);
      chk("t3_hold_valid", longint'(ov[0]), 1);
    end
    cyc(0, 1, 7, 1);
    chk("t3_release", longint'(ov[0]), 0);
    cyc(0, 1, 3, 1); cyc(0, 1, 3, 1); cyc(0, 1, 3, 1);
    chk("t3_next", get_sum(0), 16);
    cyc(0, 0, 0, 1);

    // Continuous stream, no bubbles at window boundaries.
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, i + 1, 1);
      if ((i % 4) == 3) chk("t4_sum", get_sum(0), t4_exp[i / 4]);
    end
    cyc(0, 0, 0, 1);

    // N=1 gives one result per cycle with valid held high.
    for (int i = 0; i < 3; i++) begin
      cyc(2, 1, t5_dat[i], 1);
      chk("t5_sum", get_sum(2), t5_dat[i]);
      chk("t5_valid", longint'(ov[2]), 1);
    end
    cyc(2, 0, 0, 1);

    // Reset mid-window discards the partial sum.
    cyc(0, 1, 1, 1); cyc(0, 1, 2, 1);
    do_reset(0, 1'b1, 50);
    chk("t6_rst_valid", longint'(ov[0]), 0);
    chk("t6_rst_sum", get_sum(0), 0);
    cyc(0, 1, 10, 1); cyc(0, 1, 20, 1); cyc(0, 1, 30, 1); cyc(0, 1, 40, 1);
    chk("t6_sum", get_sum(0), 100);
    cyc(0, 0, 0, 1);

    // Random traffic with random backpressure on every instance.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 300; i++) begin
        rd = 25'($urandom);
        cyc(k, $urandom_range(0, 3) != 0, longint'($signed(rd)), $urandom_range(0, 2) != 0);
      end
      cyc(k, 0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
